periph_cfg_slave: RTL and testbench

Peripheral-bus responder (target) for the SpMM accelerator configuration port. It answers the req/gnt/wen/be/id transactions that the peripheral initiator issues. It holds the job configuration registers and a trigger/status register pair, and sequences a single job: idle, start pulse to the engine, then wait for engine done. It sits between the SoC peripheral interconnect and the accelerator controller.

---
 rtl/periph_cfg_pkg.sv | 38 +++
 rtl/periph_cfg_if.sv | 28 ++
 rtl/periph_cfg_regfile.sv | 71 +++++++
 rtl/periph_cfg_slave.sv | 191 +++++++++++++++++++
 tb/tb_periph_cfg_slave.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_cfg_pkg.sv
// Shared definitions for the SpMM configuration-port responder: register map,
// decode-error pattern, job FSM states and the registered response record.
package periph_cfg_pkg;

  // Byte offsets within the decoded window
  localparam int unsigned TRIGGER_OFF  = 32'h00;
  localparam int unsigned STATUS_OFF   = 32'h04;
  localparam int unsigned CLEAR_OFF    = 32'h08;
  localparam int unsigned CFG_BASE_OFF = 32'h0C;

  localparam logic [31:0] DECERR_DATA = 32'hDEADBEEF;

  // Widest transaction ID the response record can carry
  localparam int unsigned RESP_ID_W = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          data;
    logic [RESP_ID_W-1:0] id;
  } resp_t;

  // Byte-lane merge of a write into an existing 32-bit register value
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/periph_cfg_if.sv
// Peripheral-bus request/response bundle (req/gnt/wen/be/id with a one-cycle
// registered response) shared by the initiator and the configuration responder.
interface periph_cfg_if #(
  parameter int ID_W = 10
) ();

  logic            req;
  logic            gnt;
  logic [31:0]     add;
  logic            wen;
  logic [3:0]      be;
  logic [31:0]     data;
  logic [ID_W-1:0] id;
  logic [31:0]     r_data;
  logic            r_valid;
  logic [ID_W-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );

endinterface

// File: rtl/periph_cfg_regfile.sv
// Bank of N_CFG byte-enabled 32-bit configuration registers. With
// PERIPH_CFG_SHADOW_EN defined, writes land in a staging bank copied to the active bank on commit.
module periph_cfg_regfile
  import periph_cfg_pkg::*;
#(
  parameter int N_CFG = 16,
  parameter int IDX_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            data_i,
  input  logic                   clr_i,
  input  logic                   commit_i,
  output logic [N_CFG-1:0][31:0] cfg_o,
  output logic [N_CFG-1:0][31:0] rd_o
);

`ifdef PERIPH_CFG_SHADOW_EN

  logic [N_CFG-1:0][31:0] stage_q;
  logic [N_CFG-1:0][31:0] active_q;

  // NOTE: this bank is reset on purpose -- the engine must see all-zero config
  // after rst_ni -- so it maps to flops, not RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q  <= '0;
      active_q <= '0;
    end else begin
      if (clr_i) begin
        stage_q <= '0;
      end else if (we_i) begin
        stage_q[idx_i] <= apply_be(stage_q[idx_i], data_i, be_i);
      end
      // commit samples staging before this edge's write, which cannot coincide anyway
      if (commit_i) begin
        active_q <= stage_q;
      end
    end
  end

  assign cfg_o = active_q;
  assign rd_o  = stage_q;

`else

  logic [N_CFG-1:0][31:0] cfg_q;
  logic                   unused_commit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else if (clr_i) begin
      cfg_q <= '0;
    end else if (we_i) begin
      cfg_q[idx_i] <= apply_be(cfg_q[idx_i], data_i, be_i);
    end
  end

  assign cfg_o         = cfg_q;
  assign rd_o          = cfg_q;
  assign unused_commit = commit_i;

`endif

endmodule

// File: rtl/periph_cfg_slave.sv
// Configuration-port responder for the SpMM accelerator: bus decode, response
// register and single-job FSM. Optional staging bank via PERIPH_CFG_SHADOW_EN.
module periph_cfg_slave
  import periph_cfg_pkg::*;
#(
  parameter int ID_W   = 10,
  parameter int N_CFG  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  periph_cfg_if.slave            bus,
  output logic                   start_o,
  input  logic                   done_i,
  output logic                   busy_o,
  output logic                   evt_o,
  output logic [N_CFG-1:0][31:0] cfg_o
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int IDX_W  = (N_CFG > 1) ? $clog2(N_CFG) : 1;

  localparam logic [WORD_W-1:0] TRIGGER_W  = WORD_W'(TRIGGER_OFF  >> 2);
  localparam logic [WORD_W-1:0] STATUS_W   = WORD_W'(STATUS_OFF   >> 2);
  localparam logic [WORD_W-1:0] CLEAR_W    = WORD_W'(CLEAR_OFF    >> 2);
  localparam logic [WORD_W-1:0] CFG_BASE_W = WORD_W'(CFG_BASE_OFF >> 2);

  logic                   accept;
  logic                   wr;
  logic                   rd;
  logic [WORD_W-1:0]      word;
  logic [WORD_W-1:0]      cfg_off;
  logic [IDX_W-1:0]       cfg_idx;
  logic                   hit_trig;
  logic                   hit_stat;
  logic                   hit_clr;
  logic                   hit_cfg;
  logic                   trig_req;
  logic                   clr_done;
  logic                   clr_cfg;
  logic                   cfg_we;
  logic                   cfg_clr;
  state_e                 state_q;
  state_e                 state_d;
  logic                   start_d;
  logic                   evt_d;
  logic                   done_sticky_q;
  logic [7:0]             job_cnt_q;
  logic [31:0]            status;
  logic [31:0]            rdata;
  resp_t                  resp_d;
  resp_t                  resp_q;
  logic [N_CFG-1:0][31:0] rd_cfg;
  logic                   unused_bits;

  // ---------------------------------------------------------------- decode
  assign bus.gnt = bus.req;
  assign accept  = bus.req & bus.gnt;
  assign wr      = accept & ~bus.wen;
  assign rd      = accept &  bus.wen;

  assign word     = bus.add[ADDR_W-1:2];
  assign cfg_off  = word - CFG_BASE_W;
  assign cfg_idx  = cfg_off[IDX_W-1:0];
  assign hit_trig = (word == TRIGGER_W);
  assign hit_stat = (word == STATUS_W);
  assign hit_clr  = (word == CLEAR_W);
  assign hit_cfg  = (word >= CFG_BASE_W) && (cfg_off < WORD_W'(N_CFG));

  assign trig_req = wr & hit_trig & bus.be[0] & bus.data[0];
  assign clr_done = wr & hit_clr  & bus.data[0];
  assign clr_cfg  = wr & hit_clr  & bus.data[1];

`ifdef PERIPH_CFG_SHADOW_EN
  // Staging is always writable; the active bank only changes on job start
  assign cfg_we  = wr & hit_cfg;
  assign cfg_clr = clr_cfg;
`else
  // Keep the engine's view stable for the whole job
  assign cfg_we  = wr & hit_cfg & (state_q == IDLE);
  assign cfg_clr = clr_cfg & (state_q == IDLE);
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    evt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_req) begin
          state_d = RUNNING;
          start_d = 1'b1;
        end
      end
      RUNNING: begin
        if (done_i) begin
          state_d = IDLE;
          evt_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_o       <= 1'b0;
      evt_o         <= 1'b0;
      done_sticky_q <= 1'b0;
      job_cnt_q     <= 8'h00;
    end else begin
      start_o <= start_d;
      evt_o   <= evt_d;
      // completion outranks a simultaneous clear so no finished job goes unseen
      if (evt_d) begin
        done_sticky_q <= 1'b1;
      end else if (clr_done) begin
        done_sticky_q <= 1'b0;
      end
      if (evt_d) begin
        job_cnt_q <= job_cnt_q + 8'd1;
      end
    end
  end

  assign busy_o = (state_q == RUNNING);

  // --------------------------------------------------------- register bank
  periph_cfg_regfile #(
    .N_CFG (N_CFG),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (cfg_we),
    .idx_i    (cfg_idx),
    .be_i     (bus.be),
    .data_i   (bus.data),
    .clr_i    (cfg_clr),
    .commit_i (start_d),
    .cfg_o    (cfg_o),
    .rd_o     (rd_cfg)
  );

  // -------------------------------------------------------------- response
  assign status = {16'h0000, job_cnt_q, 6'b000000, done_sticky_q, busy_o};

  always_comb begin
    rdata = DECERR_DATA;
    if (hit_trig || hit_clr) begin
      rdata = 32'h0000_0000;
    end else if (hit_stat) begin
      rdata = status;
    end else if (hit_cfg) begin
      rdata = rd_cfg[cfg_idx];
    end
  end

  always_comb begin
    resp_d.valid = accept;
    resp_d.data  = rd ? rdata : 32'h0000_0000;
    resp_d.id    = RESP_ID_W'(bus.id);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign bus.r_valid = resp_q.valid;
  assign bus.r_data  = resp_q.data;
  assign bus.r_id    = resp_q.id[ID_W-1:0];

  // Address bits outside the decoded window and the spare ID slack
  assign unused_bits = ^{bus.add[31:ADDR_W], bus.add[1:0], resp_q.id};

endmodule

// File: tb/tb_periph_cfg_slave.sv
// Self-checking bench for periph_cfg_slave: table of bus vectors plus job,
// clear, reset and counter-wrap sequences, responses checked from a scoreboard.
module tb_periph_cfg_slave;
  import periph_cfg_pkg::*;

  localparam int ID_W   = 10;
  localparam int N_CFG  = 16;
  localparam int ADDR_W = 8;

`ifdef PERIPH_CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   start_o;
  logic                   done_i;
  logic                   busy_o;
  logic                   evt_o;
  logic [N_CFG-1:0][31:0] cfg_o;

  periph_cfg_if #(.ID_W(ID_W)) bus ();

  periph_cfg_slave #(
    .ID_W   (ID_W),
    .N_CFG  (N_CFG),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .bus     (bus),
    .start_o (start_o),
    .done_i  (done_i),
    .busy_o  (busy_o),
    .evt_o   (evt_o),
    .cfg_o   (cfg_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc   = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk_i) cyc++;

  typedef struct {
    int unsigned     due;
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic            wen;
    logic [31:0]     add;
    logic [3:0]      be;
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic [31:0]     exp_rd;
    logic [31:0]     exp_cfg0;
  } vec_t;

  localparam int N_VEC = 16;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  // One bus transaction; optionally pulses done_i on the same accept edge
  task automatic xfer(input logic wen, input logic [31:0] add, input logic [3:0] be,
                      input logic [31:0] data, input logic [ID_W-1:0] id,
                      input logic [31:0] exp_rd, input logic pulse);
    exp_t e;
    @(negedge clk_i);
    bus.req  = 1'b1;
    bus.wen  = wen;
    bus.add  = add;
    bus.be   = be;
    bus.data = data;
    bus.id   = id;
    done_i   = pulse;
    #1;
    check("gnt", 32'(bus.gnt), 32'd1);
    e.due  = cyc + 1;
    e.data = wen ? exp_rd : 32'h0;
    e.id   = id;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    bus.req = 1'b0;
    done_i  = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk_i);
    done_i = 1'b1;
    @(posedge clk_i);
    #1;
    done_i = 1'b0;
  endtask

  // Response monitor: exactly one response per accept, one cycle later
  exp_t mon_e;
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("r_valid", 32'(bus.r_valid), 32'd1);
        check("r_id",    32'(bus.r_id),    32'(mon_e.id));
        check("r_data",  bus.r_data,       mon_e.data);
      end else begin
        check("r_valid_idle", 32'(bus.r_valid), 32'd0);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wen   add             be     data           id      exp_rd         exp_cfg0
    vecs[0]  = '{1'b0, 32'h0000_000C, 4'hF, 32'h1234_5678, 10'd10, 32'h0,         32'h1234_5678};
    vecs[1]  = '{1'b0, 32'h0000_000C, 4'h2, 32'hFFFF_FFFF, 10'd11, 32'h0,         32'h1234_FF78};
    vecs[2]  = '{1'b1, 32'h0000_000C, 4'h0, 32'h0,         10'd12, 32'h1234_FF78, 32'h1234_FF78};
    vecs[3]  = '{1'b1, 32'h0000_000C, 4'h0, 32'h0,         10'd13, 32'h1234_FF78, 32'h1234_FF78};
    vecs[4]  = '{1'b1, 32'h0000_0000, 4'h0, 32'h0,         10'd14, 32'h0,         32'h1234_FF78};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 4'h0, 32'h0,         10'd3,  DECERR_DATA,   32'h1234_FF78};
    vecs[6]  = '{1'b1, 32'h0000_0004, 4'h0, 32'h0,         10'd4,  32'h0,         32'h1234_FF78};
    vecs[7]  = '{1'b0, 32'h0000_00FC, 4'hF, 32'h0000_0001, 10'd16, 32'h0,         32'h1234_FF78};
    vecs[8]  = '{1'b1, 32'h0000_00FC, 4'h0, 32'h0,         10'd17, DECERR_DATA,   32'h1234_FF78};
    vecs[9]  = '{1'b0, 32'h0000_0048, 4'hF, 32'hCAFE_F00D, 10'd18, 32'h0,         32'h1234_FF78};
    vecs[10] = '{1'b1, 32'h0000_0048, 4'h0, 32'h0,         10'd19, 32'hCAFE_F00D, 32'h1234_FF78};
    vecs[11] = '{1'b0, 32'h0000_0014, 4'h9, 32'hA1B2_C3D4, 10'd20, 32'h0,         32'h1234_FF78};
    vecs[12] = '{1'b1, 32'h0000_0014, 4'h0, 32'h0,         10'd21, 32'hA100_00D4, 32'h1234_FF78};
    vecs[13] = '{1'b1, 32'hFFFF_FF0C, 4'h0, 32'h0,         10'd22, 32'h1234_FF78, 32'h1234_FF78};
    vecs[14] = '{1'b1, 32'h0000_004C, 4'h0, 32'h0,         10'd23, DECERR_DATA,   32'h1234_FF78};
    vecs[15] = '{1'b1, 32'h0000_0004, 4'h0, 32'h0,         10'd1023, 32'h0,       32'h1234_FF78};

    rst_ni   = 1'b0;
    done_i   = 1'b0;
    bus.req  = 1'b0;
    bus.wen  = 1'b0;
    bus.add  = 32'h0;
    bus.be   = 4'h0;
    bus.data = 32'h0;
    bus.id   = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    check("rst_r_valid", 32'(bus.r_valid), 32'd0);
    check("rst_r_data",  bus.r_data,       32'h0);
    check("rst_r_id",    32'(bus.r_id),    32'd0);
    check("rst_start",   32'(start_o),     32'd0);
    check("rst_busy",    32'(busy_o),      32'd0);
    check("rst_evt",     32'(evt_o),       32'd0);
    check("rst_cfg",     32'(|cfg_o),      32'd0);
    #2 rst_ni = 1'b1;
    mon_en = 1'b1;

    // Back-to-back table vectors in IDLE
    for (int i = 0; i < N_VEC; i++) begin
      xfer(vecs[i].wen, vecs[i].add, vecs[i].be, vecs[i].data, vecs[i].id, vecs[i].exp_rd, 1'b0);
      check($sformatf("vec%0d_cfg0", i), cfg_o[0], vecs[i].exp_cfg0);
    end
    check("cfg15", cfg_o[15], 32'hCAFE_F00D);
    check("cfg2",  cfg_o[2],  32'hA100_00D4);
    repeat (2) @(posedge clk_i);

    // First job
    xfer(1'b0, 32'h00, 4'h1, 32'h1, 10'd30, 32'h0, 1'b0);
    check("a_start", 32'(start_o), 32'd1);
    check("a_busy",  32'(busy_o),  32'd1);
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd31, 32'h1, 1'b0);
    check("a_start_one_cycle", 32'(start_o), 32'd0);
    xfer(1'b0, 32'h10, 4'hF, 32'hAAAA_AAAA, 10'd32, 32'h0, 1'b0);
    check("a_cfg1_held", cfg_o[1], 32'h0);
    xfer(1'b1, 32'h10, 4'h0, 32'h0, 10'd33, SHADOW ? 32'hAAAA_AAAA : 32'h0, 1'b0);
    xfer(1'b0, 32'h00, 4'h1, 32'h1, 10'd34, 32'h0, 1'b0);
    check("a_retrigger_ignored", 32'(start_o), 32'd0);
`ifndef PERIPH_CFG_SHADOW_EN
    xfer(1'b0, 32'h08, 4'hF, 32'h2, 10'd35, 32'h0, 1'b0);
    check("a_zero_while_running", cfg_o[0], 32'h1234_FF78);
`endif
    repeat (20) @(posedge clk_i);
    #1;
    check("a_busy_wait", 32'(busy_o), 32'd1);
    check("a_evt_wait",  32'(evt_o),  32'd0);
    pulse_done();
    check("a_evt",       32'(evt_o),  32'd1);
    check("a_busy_done", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("a_evt_one_cycle", 32'(evt_o), 32'd0);
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd36, 32'h0000_0102, 1'b0);
    xfer(1'b0, 32'h08, 4'hF, 32'h1, 10'd37, 32'h0, 1'b0);
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd38, 32'h0000_0100, 1'b0);
    pulse_done();
    check("idle_done_no_evt", 32'(evt_o), 32'd0);
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd39, 32'h0000_0100, 1'b0);

    // Second job: commit point and done colliding with CLEAR
    xfer(1'b0, 32'h00, 4'h1, 32'h1, 10'd40, 32'h0, 1'b0);
    check("b_start", 32'(start_o), 32'd1);
    check("b_cfg1",  cfg_o[1], SHADOW ? 32'hAAAA_AAAA : 32'h0);
    xfer(1'b0, 32'h08, 4'hF, 32'h1, 10'd41, 32'h0, 1'b1);
    check("b_evt",  32'(evt_o),  32'd1);
    check("b_busy", 32'(busy_o), 32'd0);
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd42, 32'h0000_0202, 1'b0);
    xfer(1'b0, 32'h08, 4'hF, 32'h3, 10'd43, 32'h0, 1'b0);
    check("b_cfg0_after_zero", cfg_o[0], SHADOW ? 32'h1234_FF78 : 32'h0);
    xfer(1'b1, 32'h0C, 4'h0, 32'h0, 10'd44, 32'h0, 1'b0);
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd45, 32'h0000_0200, 1'b0);

    // Reset in the middle of a job
    xfer(1'b0, 32'h18, 4'hF, 32'h55AA_55AA, 10'd46, 32'h0, 1'b0);
    xfer(1'b0, 32'h00, 4'h1, 32'h1, 10'd47, 32'h0, 1'b0);
    check("c_busy",  32'(busy_o), 32'd1);
    check("c_cfg3",  cfg_o[3],    32'h55AA_55AA);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("c_rst_busy", 32'(busy_o), 32'd0);
    check("c_rst_cfg",  32'(|cfg_o), 32'd0);
    check("c_rst_start", 32'(start_o), 32'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd48, 32'h0, 1'b0);
    pulse_done();
    check("c_done_after_rst", 32'(evt_o), 32'd0);
    xfer(1'b1, 32'h18, 4'h0, 32'h0, 10'd49, 32'h0, 1'b0);

    // Job counter wrap
    for (int j = 0; j < 255; j++) begin
      xfer(1'b0, 32'h00, 4'h1, 32'h1, ID_W'(j), 32'h0, 1'b0);
      pulse_done();
    end
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd50, 32'h0000_FF02, 1'b0);
    xfer(1'b0, 32'h00, 4'h1, 32'h1, 10'd51, 32'h0, 1'b0);
    pulse_done();
    xfer(1'b1, 32'h04, 4'h0, 32'h0, 10'd52, 32'h0000_0002, 1'b0);

    repeat (3) @(posedge clk_i);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
